// File: rtl/tcp_encoder.sv
// Transmit-side TCP segment builder: latches one FIX payload, prepends a PSH|ACK
// header, computes the checksum one 16-bit word per cycle, and tracks the send sequence.
module tcp_encoder #(
    parameter int unsigned PAYLOAD_LEN       = 262,
    parameter int unsigned TCPH_LEN          = 20,
    parameter int unsigned PSEUDO_HEADER_LEN = 12,
    parameter int unsigned PROTOCOL          = 6,
    parameter logic [31:0] SRCADDR           = 32'h7f000001,
    parameter logic [31:0] DESADDR           = 32'h7f000001,
    parameter logic [15:0] SRC_PORT          = 16'd9000,
    parameter logic [15:0] DST_PORT          = 16'd50000,
    parameter logic [15:0] WINDOW            = 16'hFFFF,
    parameter logic [31:0] INIT_SEQ          = 32'h00000000
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                tx_valid,
    output logic                                tx_ready,
    input  logic [PAYLOAD_LEN*8-1:0]            tx_fix_data,
    input  logic [31:0]                         ack_num_in,
    input  logic                                seq_load,
    input  logic [31:0]                         seq_load_val,
    output logic                                tcp_valid,
    input  logic                                tcp_ready,
    output logic [(PAYLOAD_LEN+TCPH_LEN)*8-1:0] tcp_data,
    output logic [31:0]                         tx_seq_num
);

    localparam int unsigned SEG_BYTES   = PAYLOAD_LEN + TCPH_LEN;
    localparam int unsigned SEG_W       = SEG_BYTES * 8;
    localparam int unsigned TOTAL_BYTES = PSEUDO_HEADER_LEN + SEG_BYTES;
    localparam int unsigned N_WORDS     = (TOTAL_BYTES + 1) / 2;
    localparam int unsigned STREAM_W    = N_WORDS * 16;
    localparam int unsigned SEL_W       = $clog2(STREAM_W);
    localparam int unsigned IDX_W       = $clog2(N_WORDS + 1);
    localparam int unsigned CSUM_LSB    = SEG_W - 144;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_WORDS - 1);
    localparam logic [15:0]      OFF_FLAGS = {4'(TCPH_LEN / 4), 6'b000000, 6'b011000};
    localparam logic [95:0]      PSEUDO    = {SRCADDR, DESADDR, 8'h00, 8'(PROTOCOL),
                                              16'(TCPH_LEN + PAYLOAD_LEN)};

    typedef enum logic [1:0] {IDLE, SUM, FOLD, SEND} state_t;

    state_t             state_q, state_d;
    logic [SEG_W-1:0]   seg_q, seg_d;
    logic [31:0]        acc_q, acc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               valid_q, valid_d;
    logic [31:0]        seq_q, seq_d;

    logic [STREAM_W-1:0] stream;
    logic [SEL_W-1:0]    word_base;
    logic [15:0]         word;
    logic [16:0]         fold1;
    logic [15:0]         fold2;

    assign tx_ready   = rst_n && (state_q == IDLE);
    assign tcp_valid  = valid_q;
    assign tcp_data   = seg_q;
    assign tx_seq_num = seq_q;

    always_comb begin
        state_d = state_q;
        seg_d   = seg_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        seq_d   = seq_q;

        // Word stream is left-aligned so an odd byte count gets a trailing zero pad byte.
        stream = '0;
        stream[STREAM_W-1 -: TOTAL_BYTES*8] = {PSEUDO, seg_q};
        word_base = SEL_W'((N_WORDS - 1 - 32'(idx_q)) * 16);
        word      = stream[word_base +: 16];

        fold1 = {1'b0, acc_q[15:0]} + {1'b0, acc_q[31:16]};
        fold2 = fold1[15:0] + {15'b0, fold1[16]};

        case (state_q)
            IDLE: begin
                if (tx_valid && tx_ready) begin
                    seg_d   = {SRC_PORT, DST_PORT, seq_q, ack_num_in, OFF_FLAGS, WINDOW,
                               16'h0000, 16'h0000, tx_fix_data};
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = SUM;
                end
            end
            SUM: begin
                acc_d = acc_q + {16'h0000, word};
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = FOLD;
                end
            end
            FOLD: begin
                seg_d[CSUM_LSB +: 16] = ~fold2;
                valid_d = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                if (tcp_ready) begin
                    valid_d = 1'b0;
                    seq_d   = seq_q + 32'(PAYLOAD_LEN);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // An explicit load overrides the post-send increment on the same edge.
        if (seq_load) begin
            seq_d = seq_load_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            seg_q   <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            seq_q   <= INIT_SEQ;
        end else begin
            state_q <= state_d;
            seg_q   <= seg_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            seq_q   <= seq_d;
        end
    end

endmodule

// File: tb/tb_tcp_encoder.sv
// Directed bench for tcp_encoder: default 262-byte build plus a 3-byte odd-length build.
module tb_tcp_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          tx_valid, tx_ready, seq_load, tcp_valid, tcp_ready;
    logic [2095:0] tx_fix_data;
    logic [31:0]   ack_num_in, seq_load_val, tx_seq_num;
    logic [2255:0] tcp_data;

    logic          b_tx_valid, b_tx_ready, b_seq_load, b_tcp_valid, b_tcp_ready;
    logic [23:0]   b_tx_fix_data;
    logic [31:0]   b_ack_num_in, b_seq_load_val, b_tx_seq_num;
    logic [183:0]  b_tcp_data;

    int checks   = 0;
    int failures = 0;

    logic [2095:0] p1, p2;
    logic [2255:0] snap;
    int            cnt;
    logic          rdy_seen, stable, seen;

    tcp_encoder u_dut (
        .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_fix_data(tx_fix_data), .ack_num_in(ack_num_in), .seq_load(seq_load),
        .seq_load_val(seq_load_val), .tcp_valid(tcp_valid), .tcp_ready(tcp_ready),
        .tcp_data(tcp_data), .tx_seq_num(tx_seq_num)
    );

    tcp_encoder #(.PAYLOAD_LEN(3)) u_odd (
        .clk(clk), .rst_n(rst_n), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
        .tx_fix_data(b_tx_fix_data), .ack_num_in(b_ack_num_in), .seq_load(b_seq_load),
        .seq_load_val(b_seq_load_val), .tcp_valid(b_tcp_valid), .tcp_ready(b_tcp_ready),
        .tcp_data(b_tcp_data), .tx_seq_num(b_tx_seq_num)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_seg(input string tag, input logic [2255:0] obs, input logic [2255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed_hdr=%0h expected_hdr=%0h observed_tail=%0h expected_tail=%0h",
                   tag, obs[2255:2096], exp[2255:2096], obs[63:0], exp[63:0]);
        end
    endtask

    // One's-complement sum with end-around carry applied after every word.
    function automatic logic [15:0] ref_csum(input logic [2095:0] pl, input logic [31:0] seq,
                                             input logic [31:0] ack);
        logic [95:0]   ph;
        logic [2255:0] seg;
        logic [31:0]   s;
        ph  = {32'h7f000001, 32'h7f000001, 8'h00, 8'h06, 16'd282};
        seg = {16'd9000, 16'd50000, seq, ack, 16'h5018, 16'hFFFF, 16'h0000, 16'h0000, pl};
        s   = 32'h0;
        for (int i = 0; i < 6; i++) begin
            s = s + {16'h0, ph[95-16*i -: 16]};
            if (s > 32'h0000FFFF) s = s - 32'h0000FFFF;
        end
        for (int i = 0; i < 141; i++) begin
            s = s + {16'h0, seg[2255-16*i -: 16]};
            if (s > 32'h0000FFFF) s = s - 32'h0000FFFF;
        end
        return ~s[15:0];
    endfunction

    function automatic logic [2255:0] exp_seg(input logic [2095:0] pl, input logic [31:0] seq,
                                              input logic [31:0] ack);
        return {16'h2328, 16'hC350, seq, ack, 16'h5018, 16'hFFFF, ref_csum(pl, seq, ack),
                16'h0000, pl};
    endfunction

    task automatic accept_a(input logic [2095:0] pl, input logic [31:0] ack);
        int n = 0;
        while (!tx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        tx_fix_data = pl;
        ack_num_in  = ack;
        tx_valid    = 1'b1;
        @(negedge clk);
        tx_valid    = 1'b0;
    endtask

    task automatic wait_valid_a(output int n, output logic rdy);
        n   = 0;
        rdy = 1'b0;
        while (!tcp_valid && n < 400) begin
            if (tx_ready) rdy = 1'b1;
            @(negedge clk);
            n++;
        end
        if (tx_ready) rdy = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        tx_valid = 1'b0; tx_fix_data = '0; ack_num_in = '0;
        seq_load = 1'b0; seq_load_val = '0; tcp_ready = 1'b1;
        b_tx_valid = 1'b0; b_tx_fix_data = '0; b_ack_num_in = '0;
        b_seq_load = 1'b0; b_seq_load_val = '0; b_tcp_ready = 1'b1;
        for (int i = 0; i < 262; i++) begin
            p1[2095-8*i -: 8] = 8'(i * 7 + 3);
            p2[2095-8*i -: 8] = 8'(255 - i);
        end

        repeat (2) @(negedge clk);
        chk("rst_valid", tcp_valid, 0);
        chk_seg("rst_data", tcp_data, '0);
        chk("rst_seq", tx_seq_num, 32'h0);
        chk("rst_ready_low", tx_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready_high", tx_ready, 1);

        // All-zero payload, hand-computed header.
        accept_a('0, 32'h0);
        wait_valid_a(cnt, rdy_seen);
        chk("t1_latency", cnt, 148);
        chk("t1_ready_low", rdy_seen, 0);
        chk_seg("t1_seg", tcp_data,
                {16'h2328, 16'hC350, 32'h0, 32'h0, 16'h5018, 16'hFFFF, 16'hCA4B, 16'h0000, 2096'b0});
        @(negedge clk);
        chk("t1_valid_one_cycle", tcp_valid, 0);
        chk("t1_seq", tx_seq_num, 32'h106);

        // Back-to-back sends.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        accept_a(p1, 32'h12345678);
        wait_valid_a(cnt, rdy_seen);
        chk("t2a_latency", cnt, 148);
        chk("t2a_ready_low", rdy_seen, 0);
        chk_seg("t2a_seg", tcp_data, exp_seg(p1, 32'h0, 32'h12345678));
        accept_a(p2, 32'h12345678);
        wait_valid_a(cnt, rdy_seen);
        chk("t2b_latency", cnt, 148);
        chk("t2b_ready_low", rdy_seen, 0);
        chk("t2b_seq_field", tcp_data[2223:2192], 32'h106);
        chk("t2b_ack_field", tcp_data[2191:2160], 32'h12345678);
        chk_seg("t2b_seg", tcp_data, exp_seg(p2, 32'h106, 32'h12345678));
        @(negedge clk);
        chk("t2_seq", tx_seq_num, 32'h20C);

        // Backpressure for 10 cycles while tx_valid toggles with a different payload.
        tcp_ready = 1'b0;
        accept_a(p1, 32'h12345678);
        wait_valid_a(cnt, rdy_seen);
        chk_seg("t3_seg", tcp_data, exp_seg(p1, 32'h20C, 32'h12345678));
        snap        = tcp_data;
        stable      = 1'b1;
        tx_fix_data = p2;
        for (int i = 0; i < 10; i++) begin
            tx_valid = (i % 2 == 0);
            @(negedge clk);
            if (tcp_data !== snap || tcp_valid !== 1'b1 || tx_seq_num !== 32'h20C || tx_ready !== 1'b0)
                stable = 1'b0;
        end
        chk("t3_stable", stable, 1);
        tx_valid  = 1'b0;
        tcp_ready = 1'b1;
        @(negedge clk);
        chk("t3_valid_drop", tcp_valid, 0);
        chk("t3_seq_once", tx_seq_num, 32'h312);
        @(negedge clk);
        chk("t3_no_second_accept", tx_ready, 1);

        // Sequence load then wrap.
        seq_load     = 1'b1;
        seq_load_val = 32'hFFFFFF00;
        @(negedge clk);
        seq_load = 1'b0;
        chk("t4_load", tx_seq_num, 32'hFFFFFF00);
        accept_a(p2, 32'h12345678);
        wait_valid_a(cnt, rdy_seen);
        chk_seg("t4_seg", tcp_data, exp_seg(p2, 32'hFFFFFF00, 32'h12345678));
        @(negedge clk);
        chk("t4_wrap", tx_seq_num, 32'h00000006);

        // Load on the handshake edge wins over the increment.
        tcp_ready = 1'b0;
        accept_a(p1, 32'h12345678);
        wait_valid_a(cnt, rdy_seen);
        chk_seg("t4b_seg", tcp_data, exp_seg(p1, 32'h6, 32'h12345678));
        seq_load     = 1'b1;
        seq_load_val = 32'hAAAA0000;
        tcp_ready    = 1'b1;
        @(negedge clk);
        seq_load = 1'b0;
        chk("t4b_load_wins", tx_seq_num, 32'hAAAA0000);
        chk("t4b_valid_drop", tcp_valid, 0);

        // Reset at SUM index 50.
        accept_a(p1, 32'h12345678);
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_valid", tcp_valid, 0);
        chk("t5_seq", tx_seq_num, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_ready", tx_ready, 1);
        seen = 1'b0;
        repeat (160) begin
            @(negedge clk);
            if (tcp_valid) seen = 1'b1;
        end
        chk("t5_no_output", seen, 0);
        accept_a(p2, 32'h0);
        wait_valid_a(cnt, rdy_seen);
        chk("t5_latency", cnt, 148);
        chk_seg("t5_seg", tcp_data, exp_seg(p2, 32'h0, 32'h0));
        @(negedge clk);
        chk("t5_seq_after", tx_seq_num, 32'h106);

        // Odd-length build: 3-byte payload, 18 words, last word EF00.
        chk("t6_ready", b_tx_ready, 1);
        b_tx_fix_data = 24'hABCDEF;
        b_tx_valid    = 1'b1;
        @(negedge clk);
        b_tx_valid = 1'b0;
        cnt = 0;
        while (!b_tcp_valid && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("t6_latency", cnt, 19);
        chk("t6_seg", b_tcp_data,
            {16'h2328, 16'hC350, 32'h0, 32'h0, 16'h5018, 16'hFFFF, 16'h3080, 16'h0000, 24'hABCDEF});
        @(negedge clk);
        chk("t6_valid_drop", b_tcp_valid, 0);
        chk("t6_seq", b_tx_seq_num, 32'h3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
